// File: rtl/regbank_scan_ctrl.sv
// regbank_scan_ctrl: initialises the register bank, scans register pairs for display and grants external writes.
module regbank_scan_ctrl #(
    parameter int AW    = 4,
    parameter int DW    = 4,
    parameter int DWELL = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_gnt,
    output logic [AW-1:0] addrW,
    output logic [DW-1:0] datW,
    output logic          RegWrite,
    output logic [AW-1:0] addrRa,
    output logic [AW-1:0] addrRb,
    input  logic [DW-1:0] datOutRa,
    input  logic [DW-1:0] datOutRb,
    output logic [DW-1:0] disp_a,
    output logic [DW-1:0] disp_b,
    output logic [AW-2:0] disp_idx,
    output logic          disp_valid,
    output logic          busy,
    output logic          init_done
);
    localparam int TW = $clog2(DWELL);
    localparam logic [1:0] IDLE = 2'd0, INIT = 2'd1, SCAN = 2'd2, WRITE = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] cnt, lat_addr;
    logic [DW-1:0] lat_data;
    logic [AW-2:0] k;
    logic [TW-1:0] dwell;
    logic          last;

    assign last = dwell == TW'(DWELL - 1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            k          <= '0;
            dwell      <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            disp_a     <= '0;
            disp_b     <= '0;
            disp_idx   <= '0;
            disp_valid <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            disp_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= INIT;
                    cnt   <= '0;
                end
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state     <= SCAN;
                        init_done <= 1'b1;
                        k         <= '0;
                        dwell     <= '0;
                    end
                end
                // a pending write pre-empts a capture due on the same edge
                SCAN: if (wr_req) begin
                    state    <= WRITE;
                    lat_addr <= wr_addr;
                    lat_data <= wr_data;
                    dwell    <= '0;
                end else if (last) begin
                    disp_a     <= datOutRa;
                    disp_b     <= datOutRb;
                    disp_idx   <= k;
                    disp_valid <= 1'b1;
                    dwell      <= '0;
                    k          <= k + 1'b1;
                end else begin
                    dwell <= dwell + 1'b1;
                end
                default: begin
                    state <= SCAN;
                    dwell <= '0;
                end
            endcase
        end
    end

    assign wr_gnt   = state == WRITE;
    assign RegWrite = state == INIT || wr_gnt;
    assign busy     = RegWrite;
    assign addrW    = state == INIT ? cnt : wr_gnt ? lat_addr : '0;
    assign datW     = state == INIT ? DW'(cnt) : wr_gnt ? lat_data : '0;
    assign addrRa   = {1'b0, k};
    assign addrRb   = (state == SCAN || wr_gnt) ? {1'b1, k} : '0;
endmodule

// File: tb/tb_regbank_scan_ctrl.sv
// tb_regbank_scan_ctrl: random stimulus against an edge-numbered reference model with a queue scoreboard.
module tb_regbank_scan_ctrl;
    localparam int DWELL = 4;

    logic       clk = 1'b0, rst = 1'b0, start = 1'b0, wr_req = 1'b0;
    logic [3:0] wr_addr = '0, wr_data = '0;
    logic       wr_gnt, RegWrite, disp_valid, busy, init_done;
    logic [3:0] addrW, datW, addrRa, addrRb, datOutRa, datOutRb, disp_a, disp_b;
    logic [2:0] disp_idx;
    logic [3:0] bank [16];

    int n_chk = 0, n_fail = 0;

    regbank_scan_ctrl #(.AW(4), .DW(4), .DWELL(DWELL)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_gnt(wr_gnt), .addrW(addrW), .datW(datW),
        .RegWrite(RegWrite), .addrRa(addrRa), .addrRb(addrRb), .datOutRa(datOutRa),
        .datOutRb(datOutRb), .disp_a(disp_a), .disp_b(disp_b), .disp_idx(disp_idx),
        .disp_valid(disp_valid), .busy(busy), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // register bank the controller drives
    always @(posedge clk) if (RegWrite) bank[addrW] <= datW;
    assign datOutRa = bank[addrRa];
    assign datOutRb = bank[addrRb];

    typedef struct { logic [3:0] a; logic [3:0] d; logic g; } wr_t;
    typedef struct { logic [2:0] i; logic [3:0] a; logic [3:0] b; } cap_t;
    wr_t  wq[$];
    cap_t cq[$];

    // reference: timing expressed as absolute edge numbers derived from start / grant edges
    int e = 0, mode = 0, t0 = 0, next_cap = 0, last_gnt = -10, ridx = 0;
    logic exp_done = 1'b0;
    logic [3:0] rmem [16];

    initial forever begin
        @(posedge clk);
        e++;
        if (!rst) begin
            mode = 0;
            exp_done = 1'b0;
            wq.delete();
            cq.delete();
        end else if (mode == 0) begin
            if (start) begin
                mode = 1;
                t0 = e;
                ridx = 0;
                last_gnt = -10;
                next_cap = e + 16 + DWELL;
                for (int i = 0; i < 16; i++) begin
                    wq.push_back('{a: 4'(i), d: 4'(i), g: 1'b0});
                    rmem[i] = 4'(i);
                end
            end
        end else begin
            if (e == t0 + 16) exp_done = 1'b1;
            if (e > t0 + 16) begin
                if (wr_req && e != last_gnt + 1) begin
                    wq.push_back('{a: wr_addr, d: wr_data, g: 1'b1});
                    rmem[wr_addr] = wr_data;
                    last_gnt = e;
                    next_cap = e + 1 + DWELL;
                end else if (e == next_cap) begin
                    cq.push_back('{i: 3'(ridx), a: rmem[ridx], b: rmem[ridx + 8]});
                    ridx = (ridx + 1) % 8;
                    next_cap += DWELL;
                end
            end
        end
    end

    // monitor: each expected item must appear in exactly the cycle after it was scheduled
    initial forever begin
        wr_t w;
        cap_t c;
        @(negedge clk);
        if (RegWrite || busy || wr_gnt || wq.size() > 0) begin
            n_chk++;
            if (wq.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected t=%0t got we=%b busy=%b gnt=%b addr=%h data=%h expected no write",
                         $time, RegWrite, busy, wr_gnt, addrW, datW);
            end else begin
                w = wq.pop_front();
                if ({RegWrite, busy, wr_gnt, addrW, datW} !== {1'b1, 1'b1, w.g, w.a, w.d}) begin
                    n_fail++;
                    $display("FAIL write t=%0t got we=%b busy=%b gnt=%b addr=%h data=%h expected we=1 busy=1 gnt=%b addr=%h data=%h",
                             $time, RegWrite, busy, wr_gnt, addrW, datW, w.g, w.a, w.d);
                end
            end
        end
        if (disp_valid || cq.size() > 0) begin
            n_chk++;
            if (cq.size() == 0) begin
                n_fail++;
                $display("FAIL capture_unexpected t=%0t got idx=%0d a=%h b=%h expected no capture",
                         $time, disp_idx, disp_a, disp_b);
            end else begin
                c = cq.pop_front();
                if ({disp_valid, disp_idx, disp_a, disp_b} !== {1'b1, c.i, c.a, c.b}) begin
                    n_fail++;
                    $display("FAIL capture t=%0t got valid=%b idx=%0d a=%h b=%h expected valid=1 idx=%0d a=%h b=%h",
                             $time, disp_valid, disp_idx, disp_a, disp_b, c.i, c.a, c.b);
                end
            end
        end
        n_chk++;
        if (init_done !== exp_done) begin
            n_fail++;
            $display("FAIL init_done t=%0t got %b expected %b", $time, init_done, exp_done);
        end
    end

    task automatic check_zero(input string nm);
        logic [31:0] v;
        v = {wr_gnt, addrW, datW, RegWrite, addrRa, addrRb, disp_a, disp_b, disp_idx, disp_valid, busy, init_done};
        n_chk++;
        if (v !== '0) begin
            n_fail++;
            $display("FAIL %s t=%0t got outputs %h expected 0", nm, $time, v);
        end
    endtask

    // holds the request until the grant cycle, then drops it within that cycle
    task automatic req(input logic [3:0] a, input logic [3:0] d);
        bit got = 0;
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = wr_gnt;
        end
        wr_req = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_timeout t=%0t got no wr_gnt expected one within 60 cycles", $time);
        end
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;
        wr_addr = 4'($urandom);
        wr_req = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("idle_ignores_req");
        wr_req = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("mid_init_reset");
        rst = 1'b1;
        wr_addr = 4'($urandom);
        wr_data = 4'($urandom);
        wr_req = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req(wr_addr, wr_data);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        req(4'd3, 4'hA);
        repeat (40) @(negedge clk);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = disp_valid;
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL capture_timeout t=%0t got no disp_valid expected one within 20 cycles", $time);
        end
        repeat (3) @(negedge clk);
        req(4'($urandom), 4'($urandom));
        repeat (12) @(negedge clk);
        wr_addr = 4'($urandom);
        wr_data = 4'($urandom);
        wr_req = 1'b1;
        repeat (7) @(negedge clk);
        wr_req = 1'b0;
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 10)) @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            req(4'($urandom), 4'($urandom));
        end
        repeat (40) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/regbank_scan_ctrl.md
# regbank_scan_ctrl

Sequencer for the lab register bank: it owns the bank's write port and both read ports. After `start` it loads every register with a known pattern, then continuously scans register pairs (k, k+2^(AW-1)) onto the two read ports and captures them for the seven-segment display stage. It also arbitrates an external write requester onto the bank's single write port.

## Interface
- `AW`, 4: register address width; the bank holds 2^AW registers.
- `DW`, 4: register data width.
- `DWELL`, 8: cycles each scan pair is held before capture; must be ≥ 2.

- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  begin init and scan; honoured only in IDLE
- `wr_req`  in  1  external write request, level
- `wr_addr`  in  AW  external write address
- `wr_data`  in  DW  external write data
- `wr_gnt`  out  1  high for exactly the cycle the external write is presented
- `addrW`  out  AW  bank write address
- `datW`  out  DW  bank write data
- `RegWrite`  out  1  bank write enable; the bank writes on the next edge
- `addrRa`  out  AW  bank read address A = k
- `addrRb`  out  AW  bank read address B = k + 2^(AW-1)
- `datOutRa`  in  DW  bank read data A, combinational from `addrRa`
- `datOutRb`  in  DW  bank read data B
- `disp_a`, `disp_b`  out  DW  captured pair for the display
- `disp_idx`  out  AW-1  k of the captured pair
- `disp_valid`  out  1  one-cycle pulse after each capture
- `busy`  out  1  high in INIT and WRITE
- `init_done`  out  1  sticky; high once init completes

## Operation
- Outputs are decoded from registered state and counters only. There is no combinational path from any input to any output.
- **States:** IDLE, INIT, SCAN, WRITE.
- **Reset** (`rst`=0 at an edge), from any state:
  - state becomes IDLE.
  - Counters `cnt`, `k` and `dwell` clear to 0.
  - Every output is 0, including `disp_*` and `init_done`.
  - A reset mid-INIT or mid-WRITE aborts the operation; no further bank writes are issued.
- **IDLE:**
  - All outputs hold their reset values.
  - `start`=1 moves to INIT with `cnt`=0.
  - `wr_req` is ignored.
- **INIT:**
  - Outputs: `RegWrite`=1, `addrW`=`cnt`, `datW`=`cnt[DW-1:0]`.
  - `cnt` increments each cycle.
  - At `cnt`=2^AW-1 the next state is SCAN, with `init_done`←1, `k`=0 and `dwell`=0.
  - `start` and `wr_req` are ignored.
- **SCAN:**
  - Outputs: `RegWrite`=0, `addrRa`=`k`, `addrRb`=`k`+2^(AW-1).
  - `dwell` increments each cycle.
  - When `dwell`=DWELL-1, at the edge:
    - `disp_a`←`datOutRa`, `disp_b`←`datOutRb`, `disp_idx`←`k`.
    - `disp_valid` goes high for one cycle.
    - `dwell`←0, and `k`←`k`+1, wrapping from 2^(AW-1)-1 to 0.
- **Arbitration:**
  - `wr_req` is sampled only in SCAN.
  - If `wr_req`=1 at an edge, the next state is WRITE, with `wr_addr`/`wr_data` latched.
  - A request has priority over a capture due on the same edge. That capture is skipped, and `k` is unchanged.
- **WRITE** (one cycle):
  - Outputs: `RegWrite`=1, `addrW`/`datW`=latched values, `wr_gnt`=1.
  - The next state is always SCAN with `dwell`=0, so the current pair is re-read for a full DWELL.
- **Requester rule:** the requester must drop `wr_req` in the `wr_gnt` cycle. A level still high on the first SCAN edge is granted again as a new write.
- `disp_*` hold their last captured value between captures.

## Timing
- `start` sampled at edge N:
  - Bank writes of registers 0..2^AW-1 occur at edges N+1..N+2^AW.
  - `RegWrite` is high for exactly 2^AW consecutive cycles.
  - `init_done` and SCAN begin after edge N+2^AW.
- **First capture** is at edge N+2^AW+DWELL. `disp_valid` is high the following cycle. Captures then repeat every DWELL cycles.
- **Write** sampled at edge M:
  - `wr_gnt`/`RegWrite` are high in cycle M..M+1.
  - The bank is updated at edge M+1.
  - The next capture is at edge M+1+DWELL.
- **Minimum write spacing** is 2 cycles. A continuously held `wr_req` yields a grant every other cycle and starves captures; this is the intended behaviour.

## Test plan
- **Init** (AW=4, DW=4, DWELL=4): reset, then pulse `start`.
  - `RegWrite` is high 16 cycles, with `addrW` 0..15 and `datW`=`addrW`.
  - `init_done` rises after the 16th write.
  - `busy` is high throughout.
- **Scan** (bank model attached):
  - `disp_valid` pulses every 4 cycles.
  - `disp_idx` runs 0..7 then wraps to 0.
  - Each capture shows `disp_a`=idx and `disp_b`=idx+8.
- **Write:** `wr_req`, `wr_addr`=3, `wr_data`=0xA during SCAN.
  - One `wr_gnt` cycle with `RegWrite`=1, `addrW`=3, `datW`=0xA.
  - The next capture with `disp_idx`=3 shows `disp_a`=0xA.
- **Collision:** `wr_req` sampled on the edge where `dwell`=3.
  - No capture on that edge; `k` is unchanged.
  - The next `disp_valid` follows exactly 5 cycles after that edge.
- **Gated requests:** `wr_req` held high from IDLE through INIT.
  - No `wr_gnt` until SCAN.
  - The first grant appears on the cycle after the first SCAN cycle.
  - `start` pulsed during SCAN has no effect.
- **Mid-INIT reset:** `rst`=0 for one edge after 5 init writes.
  - All outputs return to 0 and `init_done`=0.
  - A new `start` restarts the writes at `addrW`=0.
